data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of cycles spent in WAIT per access (0..15 legal).
REQ-002 Parameter DEPTH_BYTES, default 256, byte capacity of storage; SHALL be a power of two.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 MEM_ENABLE  in  1  access request from MEM stage.
REQ-006 MEM_READWRITE  in  1  0 = load (read), 1 = store (write).
REQ-007 MEM_SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 MEM_SIGNE  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 MEM_ADDR  in  32  byte address.
REQ-010 MEM_WDATA  in  32  store data, right-justified.
REQ-011 MEM_RDATA  out  32  load result, valid while MEM_READY is high.
REQ-012 MEM_READY  out  1  one-cycle completion pulse.
REQ-013 MEM_BUSY  out  1  access in progress; MEM stage holds while high.
REQ-014 MEM_ERR  out  1  completion carries an error; qualified by MEM_READY.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 In IDLE or RESP, MEM_ENABLE=1 at a rising edge: latch ADDR, WDATA, SIZE, SIGNE and READWRITE; load wait counter with WAIT_STATES; go to WAIT, or go directly to RESP when WAIT_STATES=0.
REQ-017 In IDLE or RESP with MEM_ENABLE=0: go to (or stay in) IDLE.
REQ-018 WAIT: decrement the counter each edge; at the edge where the counter is 1, go to RESP.
REQ-019 MEM_ENABLE in WAIT is ignored; latched request fields do not change.
REQ-020 Access latency: MEM_READY goes high exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-021 MEM_BUSY is high exactly while the state is WAIT.
REQ-022 MEM_READY is high exactly while the state is RESP; it is never high for two cycles unless a back-to-back request was accepted.
REQ-023 Back-to-back: a request accepted on the RESP-exit edge starts a new access with no idle cycle.
REQ-024 Byte order is big-endian: the word at address A maps byte A to bits 31:24 and byte A+3 to bits 7:0.
REQ-025 Load byte/half: the selected bits are right-justified into MEM_RDATA and extended to 32 bits per MEM_SIGNE; word loads ignore MEM_SIGNE.
REQ-026 Store: bytes are written from MEM_WDATA[7:0], [15:0] or [31:0] on the WAIT->RESP (or accept->RESP) edge; no other bytes change.
REQ-027 Errors are: SIZE=11; half with ADDR[0]=1; word with ADDR[1:0]!=0; ADDR>=DEPTH_BYTES.
REQ-028 On error: no storage write, MEM_RDATA=0, MEM_ERR=1 during RESP.
REQ-029 MEM_RDATA and MEM_ERR hold their values outside RESP until the next RESP.
REQ-030 The storage array is not reset and is implemented as a byte-addressed memory of DEPTH_BYTES entries.

Reset
REQ-031 When Reset is low: state=IDLE, counter=0, MEM_RDATA=0, MEM_READY=0, MEM_BUSY=0, MEM_ERR=0, latched request fields=0.
REQ-032 Reset asserted mid-access aborts the access; a store in WAIT does not write.
REQ-033 After Reset is released, the first rising edge with MEM_ENABLE=1 is accepted normally.

Verification
REQ-034 WAIT_STATES=2: word store 0xDEADBEEF at 0x10, then word load at 0x10 -> READY pulse 3 cycles after each accept; BUSY high 2 cycles; RDATA=0xDEADBEEF; ERR=0.
REQ-035 After REQ-034: byte load at 0x13 with SIGNE=1 -> 0xFFFFFFEF; half load at 0x10 with SIGNE=0 -> 0x0000DEAD; half load at 0x12 with SIGNE=1 -> 0xFFFFBEEF.
REQ-036 Byte store 0x5A at 0x11 over 0xDEADBEEF, then word load at 0x10 -> 0xDE5ABEEF.
REQ-037 Error cases, each -> READY with ERR=1, RDATA=0, memory unchanged: word load at 0x12; half store at 0x11; SIZE=11; ADDR=0x100 with DEPTH_BYTES=256.
REQ-038 Reset pulled low in the second WAIT cycle of a word store of 0x12345678 to 0x20 (old value 0) -> outputs zero immediately; a later load at 0x20 returns 0x00000000.
REQ-039 WAIT_STATES=0: MEM_ENABLE held high for 3 consecutive loads -> READY high on 3 consecutive cycles, BUSY never high.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian data memory behind a fixed-latency request/response handshake.
// Each access waits WAIT_STATES cycles, then signals one response cycle carrying data and error status.
module data_mem_responder #(
   parameter int WAIT_STATES = 2,
   parameter int DEPTH_BYTES = 256
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MEM_ENABLE,
   input  logic        MEM_READWRITE,
   input  logic [1:0]  MEM_SIZE,
   input  logic        MEM_SIGNE,
   input  logic [31:0] MEM_ADDR,
   input  logic [31:0] MEM_WDATA,
   output logic [31:0] MEM_RDATA,
   output logic        MEM_READY,
   output logic        MEM_BUSY,
   output logic        MEM_ERR
);

   localparam int          AW          = $clog2(DEPTH_BYTES);
   localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);
   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_BYTES);

   typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        lat_rw, lat_signe;
   logic [1:0]  lat_size;
   logic [31:0] lat_addr, lat_wdata;
   logic [7:0]  mem [DEPTH_BYTES];

   function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
      case (size)
         2'b00:   return addr >= DEPTH_LIMIT;
         2'b01:   return addr[0] || (addr >= DEPTH_LIMIT);
         2'b10:   return (addr[1:0] != 2'b00) || (addr >= DEPTH_LIMIT);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [1:0] size, input logic signe,
                                               input logic [31:0] raw);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      b = raw[7:0];
      h = raw[15:0];
      case (size)
         2'b00: begin
            ext = b;
            return signe ? ext : {24'd0, raw[7:0]};
         end
         2'b01: begin
            ext = h;
            return signe ? ext : {16'd0, raw[15:0]};
         end
         default: return raw;
      endcase
   endfunction

   logic          in_wait, accept, complete;
   logic          cur_rw, cur_signe, cur_err;
   logic [1:0]    cur_size;
   logic [31:0]   cur_addr, cur_wdata, rd_raw, resp_data;
   logic [AW-1:0] idx0, idx1, idx2, idx3;

   assign in_wait  = (state == WAIT);
   assign accept   = !in_wait && MEM_ENABLE;
   assign complete = in_wait ? (wait_cnt == 4'd1) : (accept && (WAIT_STATES == 0));

   // The completing access comes from the latch while waiting, or straight from the inputs with zero wait states.
   assign cur_rw    = in_wait ? lat_rw    : MEM_READWRITE;
   assign cur_signe = in_wait ? lat_signe : MEM_SIGNE;
   assign cur_size  = in_wait ? lat_size  : MEM_SIZE;
   assign cur_addr  = in_wait ? lat_addr  : MEM_ADDR;
   assign cur_wdata = in_wait ? lat_wdata : MEM_WDATA;
   assign cur_err   = access_error(cur_size, cur_addr);

   // Half and word accesses are aligned when error-free, so the lane indices need no carry.
   assign idx0 = cur_addr[AW-1:0];
   assign idx1 = {cur_addr[AW-1:1], 1'b1};
   assign idx2 = {cur_addr[AW-1:2], 2'b10};
   assign idx3 = {cur_addr[AW-1:2], 2'b11};

   always_comb begin
      rd_raw = '0;
      case (cur_size)
         2'b00:   rd_raw = {24'd0, mem[idx0]};
         2'b01:   rd_raw = {16'd0, mem[idx0], mem[idx1]};
         default: rd_raw = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
      endcase
   end

   assign resp_data = (cur_err || cur_rw) ? 32'd0 : load_extend(cur_size, cur_signe, rd_raw);

   always_ff @(posedge Clk) begin
      if (complete && cur_rw && !cur_err) begin
         case (cur_size)
            2'b00: mem[idx0] <= cur_wdata[7:0];
            2'b01: begin
               mem[idx0] <= cur_wdata[15:8];
               mem[idx1] <= cur_wdata[7:0];
            end
            default: begin
               mem[idx0] <= cur_wdata[31:24];
               mem[idx1] <= cur_wdata[23:16];
               mem[idx2] <= cur_wdata[15:8];
               mem[idx3] <= cur_wdata[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_rw    <= 1'b0;
         lat_signe <= 1'b0;
         lat_size  <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         MEM_RDATA <= '0;
         MEM_READY <= 1'b0;
         MEM_BUSY  <= 1'b0;
         MEM_ERR   <= 1'b0;
      end else begin
         MEM_READY <= 1'b0;
         MEM_BUSY  <= 1'b0;
         if (in_wait) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt != 4'd1) MEM_BUSY <= 1'b1;
         end else if (accept) begin
            lat_rw    <= MEM_READWRITE;
            lat_signe <= MEM_SIGNE;
            lat_size  <= MEM_SIZE;
            lat_addr  <= MEM_ADDR;
            lat_wdata <= MEM_WDATA;
            wait_cnt  <= WAIT_INIT;
            if (WAIT_STATES != 0) begin
               state    <= WAIT;
               MEM_BUSY <= 1'b1;
            end
         end else begin
            state <= IDLE;
         end
         if (complete) begin
            state     <= RESP;
            MEM_READY <= 1'b1;
            MEM_RDATA <= resp_data;
            MEM_ERR   <= cur_err;
         end
      end
   end

endmodule
